// File: rtl/ireg_burst_bank.sv
// Operand register bank: direct write, streaming burst loader, clear sweep,
// and N_RD independent read ports with an optional registered write-first read.
// Ports: clk, rst_n, wr/wr_addr/wr_data, load_start/load_base/load_len,
//        in_valid/in_data/in_ready, load_done, clr_start, clr_done, busy,
//        rd_addr (packed N_RD x AW), rd_data (packed N_RD x DATA_W).
module ireg_burst_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int N_RD   = 4,
  parameter int RD_REG = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   load_start,
  input  logic [AW-1:0]          load_base,
  input  logic [AW:0]            load_len,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   load_done,
  input  logic                   clr_start,
  output logic                   clr_done,
  output logic                   busy,
  input  logic [N_RD*AW-1:0]     rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data
);

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH-1);
  localparam logic [AW:0]   LP_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [AW-1:0]       r_ptr;
  logic [AW-1:0]       w_ptr_n;
  logic [AW:0]         r_rem;
  logic [AW:0]         w_rem_n;
  logic [AW-1:0]       r_idx;
  logic [AW-1:0]       w_idx_n;
  logic                r_load_done;
  logic                w_load_done_n;
  logic                r_clr_done;
  logic                w_clr_done_n;

  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wr_ok;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_load_done <= 1'b0;
      r_clr_done  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      r_rem       <= w_rem_n;
      r_idx       <= w_idx_n;
      r_load_done <= w_load_done_n;
      r_clr_done  <= w_clr_done_n;
    end
  end

  // One write source per cycle; the FSM state picks which one owns it.
  always_comb begin
    w_state_n     = r_state;
    w_ptr_n       = r_ptr;
    w_rem_n       = r_rem;
    w_idx_n       = r_idx;
    w_load_done_n = 1'b0;
    w_clr_done_n  = 1'b0;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (clr_start) begin
          w_state_n = ST_CLEAR;
          w_idx_n   = '0;
        end else if (load_start) begin
          if (load_len == '0) begin
            w_load_done_n = 1'b1;
          end else begin
            w_state_n = ST_LOAD;
            w_ptr_n   = load_base;
            w_rem_n   = load_len;
          end
        end else if (wr) begin
          w_we    = 1'b1;
          w_waddr = wr_addr;
          w_wdata = wr_data;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          w_we    = 1'b1;
          w_waddr = r_ptr;
          w_wdata = in_data;
          w_ptr_n = (r_ptr >= LP_LAST) ? '0 : r_ptr + 1'b1;
          w_rem_n = r_rem - 1'b1;
          if (r_rem == LP_ONE) begin
            w_state_n     = ST_IDLE;
            w_load_done_n = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        w_wdata = '0;
        if (r_idx == LP_LAST) begin
          w_state_n    = ST_IDLE;
          w_clr_done_n = 1'b1;
        end else begin
          w_idx_n = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // Addresses past the last entry only exist for non power-of-two depths.
  assign w_wr_ok = w_we && ({1'b0, w_waddr} < LP_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign busy      = (r_state != ST_IDLE);
  assign load_done = r_load_done;
  assign clr_done  = r_clr_done;

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [AW-1:0]     w_ra;
    logic [DATA_W-1:0] w_rv;

    assign w_ra = rd_addr[k*AW +: AW];
    assign w_rv = ({1'b0, w_ra} < LP_DEPTH) ? r_mem[w_ra] : '0;

    if (RD_REG != 0) begin : g_reg
      logic [DATA_W-1:0] r_rd;

      // Write-first: a same-cycle write to the read address wins.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd <= '0;
        end else if (w_wr_ok && (w_waddr == w_ra)) begin
          r_rd <= w_wdata;
        end else begin
          r_rd <= w_rv;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = r_rd;
    end else begin : g_comb
      assign rd_data[k*DATA_W +: DATA_W] = w_rv;
    end
  end

endmodule

// File: tb/tb_ireg_burst_bank.sv
// Bench for ireg_burst_bank: combinational and registered-read instances
// share stimulus; read results are checked through a scoreboard queue.
module tb_ireg_burst_bank;

  localparam int DW = 8;
  localparam int DP = 32;
  localparam int NR = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          clr_start;
  logic [NR*AW-1:0] rd_addr;

  logic          in_ready0, load_done0, clr_done0, busy0;
  logic          in_ready1, load_done1, clr_done1, busy1;
  logic [NR*DW-1:0] rd_data0, rd_data1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] model [DP];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  always #5 clk = ~clk;

  ireg_burst_bank #(.DATA_W(DW), .DEPTH(DP), .N_RD(NR), .RD_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .load_done(load_done0), .clr_start(clr_start), .clr_done(clr_done0),
    .busy(busy0), .rd_addr(rd_addr), .rd_data(rd_data0)
  );

  ireg_burst_bank #(.DATA_W(DW), .DEPTH(DP), .N_RD(NR), .RD_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .load_done(load_done1), .clr_start(clr_start), .clr_done(clr_done1),
    .busy(busy1), .rd_addr(rd_addr), .rd_data(rd_data1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input int a0, input int a1, input int a2,
                        input int a3);
    int a [NR];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int p = 0; p < NR; p++) begin
      rd_addr[p*AW +: AW] = AW'(a[p]);
      q0.push_back(model[a[p]]);
      q1.push_back(model[a[p]]);
    end
    tick();
    for (int p = 0; p < NR; p++) begin
      check($sformatf("comb_rd%0d@%0d", p, a[p]),
            32'(rd_data0[p*DW +: DW]), 32'(q0.pop_front()));
      check($sformatf("reg_rd%0d@%0d", p, a[p]),
            32'(rd_data1[p*DW +: DW]), 32'(q1.pop_front()));
    end
  endtask

  task automatic status(input string tag, input logic b, input logic rdy,
                        input logic ld, input logic cd);
    check({tag, "_busy"}, 32'(busy0), 32'(b));
    check({tag, "_rdy"}, 32'(in_ready0), 32'(rdy));
    check({tag, "_ldone"}, 32'(load_done0), 32'(ld));
    check({tag, "_cdone"}, 32'(clr_done0), 32'(cd));
    check({tag, "_busy1"}, 32'(busy1), 32'(b));
  endtask

  initial begin
    int cnt;
    int pulses;
    rst_n = 1'b0; wr = 1'b1; wr_addr = 5; wr_data = 8'h77;
    load_start = 0; load_base = 0; load_len = 0;
    in_valid = 0; in_data = 0; clr_start = 0; rd_addr = '0;
    for (int i = 0; i < DP; i++) model[i] = '0;

    // Reset held while a write is requested.
    tick(); tick();
    status("rst", 0, 0, 0, 0);
    rd_chk(5, 5, 0, 31);

    rst_n = 1'b1; wr = 1'b0;
    tick();

    // Direct write then read on port 2.
    wr = 1; wr_addr = 5; wr_data = 8'hA5; model[5] = 8'hA5;
    tick();
    wr = 0;
    rd_chk(0, 1, 5, 4);

    // Burst with wrap and an in_valid gap.
    load_start = 1; load_base = 30; load_len = 4;
    tick();
    load_start = 0;
    status("ld_go", 1, 1, 0, 0);
    in_valid = 1; in_data = 11; tick();
    in_data = 22; tick();
    in_valid = 0;
    wr = 1; wr_addr = 3; wr_data = 8'h99;
    load_start = 1; load_base = 2; load_len = 1;
    tick();
    wr = 0; load_start = 0;
    status("ld_gap", 1, 1, 0, 0);
    in_valid = 1; in_data = 33; tick();
    status("ld_b3", 1, 1, 0, 0);
    in_data = 44; tick();
    in_valid = 0;
    status("ld_end", 0, 0, 1, 0);
    tick();
    status("ld_post", 0, 0, 0, 0);
    model[30] = 11; model[31] = 22; model[0] = 33; model[1] = 44;
    rd_chk(30, 31, 0, 1);
    rd_chk(3, 2, 5, 29);

    // Zero-length burst.
    load_start = 1; load_base = 8; load_len = 0;
    tick();
    load_start = 0;
    status("zl", 0, 0, 1, 0);
    tick();
    status("zl_post", 0, 0, 0, 0);
    rd_chk(8, 30, 0, 1);

    // Fill with FF, then simultaneous clr/load/wr: only clear runs.
    for (int i = 0; i < DP; i++) begin
      wr = 1; wr_addr = AW'(i); wr_data = 8'hFF; model[i] = 8'hFF;
      tick();
    end
    wr = 0;
    rd_chk(0, 9, 17, 31);
    clr_start = 1; load_start = 1; load_base = 4; load_len = 2;
    wr = 1; wr_addr = 9; wr_data = 8'h55;
    tick();
    clr_start = 0; load_start = 0; wr = 0;
    cnt = 0; pulses = 0;
    while (busy0 && cnt < 100) begin
      check("clr_rdy_low", 32'(in_ready0), 32'(0));
      cnt++;
      tick();
      pulses += int'(clr_done0);
    end
    tick();
    pulses += int'(clr_done0);
    check("clr_cycles", 32'(cnt), 32'(32));
    check("clr_pulses", 32'(pulses), 32'(1));
    status("clr_post", 0, 0, 0, 0);
    for (int i = 0; i < DP; i++) model[i] = '0;
    rd_chk(0, 9, 4, 31);
    rd_chk(5, 16, 30, 1);

    // Same-cycle write and read of entry 7 on every port.
    wr = 1; wr_addr = 7; wr_data = 8'h3C; model[7] = 8'h3C;
    rd_chk(7, 7, 7, 7);
    wr = 0;
    rd_chk(7, 6, 8, 7);

    // Reset in the middle of a burst.
    load_start = 1; load_base = 10; load_len = 4;
    tick();
    load_start = 0;
    in_valid = 1; in_data = 8'h5A; tick();
    in_data = 8'h6B; tick();
    in_valid = 0;
    rst_n = 0;
    #1;
    status("mid_rst", 0, 0, 0, 0);
    tick();
    tick();
    status("mid_rst_hold", 0, 0, 0, 0);
    rst_n = 1;
    tick();
    status("mid_rst_rel", 0, 0, 0, 0);
    for (int i = 0; i < DP; i++) model[i] = '0;
    rd_chk(10, 11, 12, 7);
    rd_chk(5, 30, 31, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ireg_burst_bank.md
Name: ireg_burst_bank

Overview:
Parametrised operand register bank for the matrix-multiply datapath. It is the next generation of the input register file: generic width, depth and read-port count, an optional registered read with write-first bypass, and two sequencers. A streaming burst loader with a valid/ready handshake fills consecutive entries from a base address. A clear engine zeroes the whole bank one entry per cycle. The PE array reads operands through N_RD independent read ports.

Parameters:
DATA_W, 8, entry width in bits
DEPTH, 32, number of entries (>=2, need not be a power of two)
N_RD, 4, number of read ports (>=1)
RD_REG, 0, 0 = combinational read; 1 = registered read (1-cycle latency) with write-first bypass
AW, $clog2(DEPTH), localparam, address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr  in  1  direct single-entry write strobe (honoured only in IDLE)
wr_addr  in  AW  direct write address
wr_data  in  DATA_W  direct write data
load_start  in  1  start burst load (honoured only in IDLE)
load_base  in  AW  first entry address of the burst
load_len  in  AW+1  number of beats in the burst
in_valid  in  1  burst data valid
in_data  in  DATA_W  burst data
in_ready  out  1  bank accepts burst beat
load_done  out  1  1-cycle pulse: burst complete
clr_start  in  1  start clear sweep (honoured only in IDLE)
clr_done  out  1  1-cycle pulse: clear complete
busy  out  1  FSM not in IDLE
rd_addr  in  N_RD*AW  packed read addresses; port k = bits [k*AW +: AW]
rd_data  out  N_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset (rst_n=0, asynchronous): all entries 0; FSM IDLE; in_ready, load_done, clr_done, busy = 0; registered rd_data = 0 (RD_REG=1); burst pointer and counters = 0. Reset mid-burst or mid-clear aborts the operation immediately with no done pulse.
- FSM states: IDLE, LOAD, CLEAR. busy = (state != IDLE).
- IDLE start priority in one cycle: clr_start > load_start > wr. A lower-priority request in the same cycle is dropped, not queued.
- IDLE, wr=1 and no start: mem[wr_addr] <= wr_data.
- IDLE, load_start=1 and load_len=0: no writes; load_done pulses next cycle; stays IDLE.
- IDLE, load_start=1 and load_len>0: capture ptr=load_base and remaining=load_len; go to LOAD.
- LOAD: in_ready=1. Each cycle with in_valid=1 writes mem[ptr] <= in_data, then ptr advances; ptr wraps DEPTH-1 -> 0.
- LOAD, last beat (remaining=1): the cycle after the last accepted beat shows load_done=1, in_ready=0 and state IDLE.
- load_len > DEPTH is legal: wrap overwrites earlier beats, and the last write wins.
- in_valid gaps in LOAD stall the burst indefinitely with no timeout.
- IDLE, clr_start=1: go to CLEAR with idx=0.
- CLEAR: writes mem[idx] <= 0 each cycle for idx 0..DEPTH-1 (exactly DEPTH cycles). clr_done pulses the cycle after idx=DEPTH-1 is written; state returns to IDLE.
- While busy, wr, load_start and clr_start are ignored.
- Address range: a write address >= DEPTH is ignored; a read address >= DEPTH returns 0. This applies only when DEPTH is not a power of two.
- RD_REG=0: rd_data[k] = mem[rd_addr[k]] combinationally. A write is visible after its clock edge.
- RD_REG=1: rd_data[k] is registered, 1-cycle latency. If rd_addr[k] matches the entry written in the same cycle (any write source, including clear), the register captures the new value (write-first bypass).
- All N_RD ports are independent; identical addresses on several ports are legal and return identical data.

Test Plan:
- Reset and direct write: hold rst_n=0 with writes active -> all rd_data=0, busy=0. Release; wr addr 5 = 8'hA5; read port 2 addr 5 -> 8'hA5 next cycle (RD_REG=0).
- Burst wrap: load_base=30, load_len=4, beats 11,22,33,44 with an in_valid gap after beat 2 -> mem[30]=11, mem[31]=22, mem[0]=33, mem[1]=44. load_done is a single pulse after beat 4; in_ready held through the gap.
- Zero length and ignored requests: load_len=0 -> load_done next cycle, no entry changes. load_start or wr during LOAD -> ignored, burst contents unchanged.
- Clear sweep: fill all entries with 8'hFF, then clr_start -> busy exactly 32 cycles, clr_done once, all reads 0. A clr_start+load_start+wr in the same cycle -> only the clear runs.
- Bypass (RD_REG=1): wr addr 7 = 8'h3C while port 0 reads addr 7 -> rd_data port 0 = 8'h3C on the next cycle, not the old value.
- Reset mid-burst: assert rst_n=0 after 2 of 4 beats -> immediate IDLE, no load_done, all entries 0.
